nios_sd_stream_mem_writer: RTL and testbench

NIOS_SD_STREAM_MEM_WRITER -- requirements
Module: nios_sd_stream_mem_writer

---
 rtl/nios_sd_stream_mem_writer_if.sv | 30 +++
 rtl/nios_sd_stream_mem_writer.sv | 162 ++++++++++++++++
 tb/tb_nios_sd_stream_mem_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_sd_stream_mem_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios_sd_stream_mem_writer_if : byte stream in, 32-bit memory write out   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface nios_sd_stream_mem_writer_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;

  // master: the writer block (stream sink, memory master)
  modport master (
    input  s_data, s_valid,
    output s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );

  // slave: the surrounding SD reader and on-chip memory
  modport slave (
    output s_data, s_valid,
    input  s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );
endinterface
`default_nettype wire

// File: rtl/nios_sd_stream_mem_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios_sd_stream_mem_writer : packs SD bytes little-endian into words      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nios_sd_stream_mem_writer #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 18
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [CNT_W-1:0]  byte_count,
  nios_sd_stream_mem_writer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [ADDR_W:0]        words_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              overflow_q, overflow_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_byteenable_q, mem_byteenable_d;
  logic [31:0]       mem_writedata_q, mem_writedata_d;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    lane_d           = lane_q;
    be_d             = be_q;
    data_d           = data_q;
    words_d          = words_q;
    overflow_d       = overflow_q;
    mem_address_d    = '0;
    mem_byteenable_d = '0;
    mem_writedata_d  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          words_d    = '0;
          overflow_d = 1'b0;
          if (byte_count != '0) begin
            addr_d      = base_addr;
            remaining_d = byte_count;
            lane_d      = 2'd0;
            be_d        = 4'd0;
            data_d      = 32'd0;
            state_d     = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (bus.s_valid) begin
          data_d[{lane_q, 3'b000} +: 8] = bus.s_data;
          be_d[lane_q] = 1'b1;
          remaining_d  = remaining_q - CNT_W'(1);
          lane_d       = lane_q + 2'd1;
          // Outputs are registered, so the write beat is staged on the accepting edge
          if (lane_q == 2'd3 || remaining_q == CNT_W'(1)) begin
            state_d          = WRITE;
            mem_address_d    = addr_q;
            mem_byteenable_d = be_d;
            mem_writedata_d  = data_d;
          end
        end
      end
      WRITE: begin
        words_d = words_q + (ADDR_W+1)'(1);
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (addr_q == {ADDR_W{1'b1}}) begin
          overflow_d = 1'b1;
          state_d    = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          lane_d  = 2'd0;
          be_d    = 4'd0;
          data_d  = 32'd0;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == FILL);
    busy_d      = (state_d == FILL) || (state_d == WRITE);
    done_d      = (state_d == DONE);
    mem_write_d = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      remaining_q      <= '0;
      lane_q           <= 2'd0;
      be_q             <= 4'd0;
      data_q           <= 32'd0;
      words_q          <= '0;
      overflow_q       <= 1'b0;
      s_ready_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_byteenable_q <= 4'd0;
      mem_writedata_q  <= 32'd0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      remaining_q      <= remaining_d;
      lane_q           <= lane_d;
      be_q             <= be_d;
      data_q           <= data_d;
      words_q          <= words_d;
      overflow_q       <= overflow_d;
      s_ready_q        <= s_ready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_byteenable_q <= mem_byteenable_d;
      mem_writedata_q  <= mem_writedata_d;
    end
  end

  assign bus.s_ready        = s_ready_q;
  assign bus.mem_chipselect = mem_write_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_byteenable = mem_byteenable_q;
  assign bus.mem_writedata  = mem_writedata_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overflow           = overflow_q;
  assign words_written      = words_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_sd_stream_mem_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nios_sd_stream_mem_writer : transfer table plus write scoreboard      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nios_sd_stream_mem_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [17:0] byte_count;
  logic        busy, done, overflow;
  logic [16:0] words_written;

  nios_sd_stream_mem_writer_if #(.ADDR_W(16)) bus ();

  nios_sd_stream_mem_writer #(.ADDR_W(16), .CNT_W(18)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .byte_count    (byte_count),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [17:0] count;
    int          gap;
    bit          inject;
    logic [7:0]  seed;
    int          exp_words;
    bit          exp_ovf;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference packing: byte k of a transfer is seed+k+1, little-endian lanes
  task automatic model(input logic [15:0] base, input logic [17:0] count,
                       input logic [7:0] seed, output int n_acc);
    int          rem;
    int          k;
    logic [15:0] a;
    wr_t         w;
    rem = int'(count); a = base; k = 0; n_acc = 0;
    while (rem > 0) begin
      w.a = a; w.d = '0; w.be = '0;
      for (int l = 0; l < 4; l++) begin
        if (rem > 0) begin
          w.d[8*l +: 8] = seed + 8'(k) + 8'd1;
          w.be[l] = 1'b1;
          rem--; k++; n_acc++;
        end
      end
      exp_q.push_back(w);
      if (rem == 0 || a == 16'hFFFF) break;
      a = a + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_write || bus.mem_chipselect) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h be %0h expected no write",
                 bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_strobes", {bus.mem_chipselect, bus.mem_write}, 2'b11);
        chk("wr_addr", bus.mem_address, w.a);
        chk("wr_data", bus.mem_writedata, w.d);
        chk("wr_be", bus.mem_byteenable, w.be);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acc);
    bus.s_data = b; bus.s_valid = 1'b1; acc = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bus.s_ready) begin
        tick();
        acc = 1'b1;
        break;
      end
      if (!busy) break;
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done) begin got = 1'b1; break; end
      tick();
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    n_acc;
    bit    acc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    model(v.base, v.count, v.seed, n_acc);
    base_addr = v.base; byte_count = v.count; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < int'(v.count); i++) begin
      if (v.inject && i == 1) begin
        start = 1'b1; base_addr = 16'h0099; byte_count = 18'd100;
      end
      send_byte(v.seed + 8'(i) + 8'd1, acc);
      start = 1'b0;
      chk({tag, "_accept"}, acc, (i < n_acc));
      if (v.gap > 0 && i + 1 < n_acc && ((i + 1) % 4) != 0) begin
        for (int g = 0; g < v.gap; g++) begin
          tick();
          chk({tag, "_ready_in_gap"}, bus.s_ready, 1'b1);
        end
      end
    end
    wait_done(tag);
    chk({tag, "_words"}, words_written, 17'(v.exp_words));
    chk({tag, "_overflow"}, overflow, v.exp_ovf);
    tick();
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    vecs[0] = '{16'h0010, 18'd8,  0, 1'b0, 8'h00, 2, 1'b0};
    vecs[1] = '{16'h0020, 18'd6,  0, 1'b0, 8'h00, 2, 1'b0};
    vecs[2] = '{16'h0030, 18'd4,  3, 1'b0, 8'h40, 1, 1'b0};
    vecs[3] = '{16'hFFFF, 18'd8,  0, 1'b0, 8'h80, 1, 1'b1};
    vecs[4] = '{16'h0070, 18'd4,  0, 1'b1, 8'h20, 1, 1'b0};
    vecs[5] = '{16'h0050, 18'd13, 1, 1'b0, 8'hA0, 4, 1'b0};
    vecs[6] = '{16'hFFFF, 18'd4,  0, 1'b0, 8'h60, 1, 1'b0};
    vecs[7] = '{16'hFFFE, 18'd9,  0, 1'b0, 8'hC0, 2, 1'b1};

    reset = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
    bus.s_data = '0; bus.s_valid = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_words", words_written, 17'd0);
    chk("rst_mem", {bus.mem_chipselect, bus.mem_write, bus.mem_address,
                    bus.mem_byteenable, bus.mem_writedata}, '0);
    reset = 1'b0;
    tick();

    // Reset after two accepted bytes: partial word discarded, reset beats start
    base_addr = 16'h0060; byte_count = 18'd8; start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h11, acc); chk("rstmid_acc0", acc, 1'b1);
    send_byte(8'h22, acc); chk("rstmid_acc1", acc, 1'b1);
    reset = 1'b1; start = 1'b1; base_addr = 16'h0061; byte_count = 18'd4;
    bus.s_valid = 1'b1; bus.s_data = 8'hAA;
    tick();
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_s_ready", bus.s_ready, 1'b0);
    chk("rstmid_words", words_written, 17'd0);
    reset = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
    repeat (5) tick();
    chk("rstmid_idle_after", busy, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Zero-length transfer straight after an overflowing one
    base_addr = 16'h0005; byte_count = 18'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_words", words_written, 17'd0);
    chk("zero_overflow", overflow, 1'b0);
    tick();
    chk("zero_done_one_cycle", done, 1'b0);
    repeat (3) tick();
    chk("zero_no_writes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
